fetch_queue: RTL and testbench

//  Parametrised successor to the fixed 16-bit PC counter: PC generator plus prefetch FIFO.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fetch_queue_sync_fifo.sv | 73 +++++++
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and default widths for the instruction fetch path.
package fetch_queue_pkg;

    localparam int FQ_PC_W    = 16;
    localparam int FQ_INSTR_W = 16;

    typedef enum logic [1:0] {
        FQ_RUN  = 2'd0,
        FQ_HOLD = 2'd1,
        FQ_HALT = 2'd2
    } fq_state_t;

    typedef struct packed {
        logic [FQ_PC_W-1:0]    pc;
        logic [FQ_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with single-cycle flush, combinational head read and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// PC generator plus prefetch FIFO feeding the decoder over valid/ready.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              PC_W    = FQ_PC_W,
    parameter int              INSTR_W = FQ_INSTR_W,
    parameter int              DEPTH   = 4,
    parameter logic [PC_W-1:0] RST_PC  = '0,
    parameter int              PC_STEP = 1
) (
    input  logic                      clk_i,
    input  logic                      rst,
    output logic [PC_W-1:0]           imem_adr_o,
    input  logic [INSTR_W-1:0]        instr_i,
    input  logic                      jmp_i,
    input  logic [PC_W-1:0]           jmp_adr_i,
    input  logic                      hold_i,
    input  logic                      halt_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [INSTR_W-1:0]        instr_o,
    output logic [PC_W-1:0]           pc_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      halted_o
);

    localparam int              EW   = PC_W + INSTR_W;
    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    fq_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            push, pop;
    logic            fifo_full, fifo_empty;
    logic [EW-1:0]   head;

    // Handshake: an entry transfers on a rising clk_i edge where valid_o & ready_i.
    // valid_o is suppressed during a redirect so no stale entry is consumed.
    assign valid_o = ~fifo_empty & ~jmp_i;
    assign pop     = valid_o & ready_i;
    assign push    = (state_q == FQ_RUN) & ~hold_i & ~halt_i & ~jmp_i & (~fifo_full | pop);

    assign imem_adr_o = pc_q;
    assign pc_o       = head[EW-1:INSTR_W];
    assign instr_o    = head[INSTR_W-1:0];
    assign halted_o   = (state_q == FQ_HALT);

    always_comb begin
        state_d = state_q;
        if (jmp_i) begin
            state_d = FQ_RUN;
        end else begin
            case (state_q)
                FQ_RUN: begin
                    if (halt_i)      state_d = FQ_HALT;
                    else if (hold_i) state_d = FQ_HOLD;
                end
                FQ_HOLD: begin
                    if (halt_i)       state_d = FQ_HALT;
                    else if (!hold_i) state_d = FQ_RUN;
                end
                FQ_HALT: state_d = FQ_HALT;
                default: state_d = FQ_RUN;
            endcase
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (jmp_i)     pc_d = jmp_adr_i;
        else if (push) pc_d = pc_q + STEP;
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q <= FQ_RUN;
            pc_q    <= RST_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (jmp_i),
        .data_i  ({pc_q, instr_i}),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (level_o)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: scoreboard of consumed {pc, instr} plus per-cycle status checks.
module tb_fetch_queue;

    logic        clk_i = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem_adr_o;
    logic [15:0] instr_i;
    logic        jmp_i = 1'b0;
    logic [15:0] jmp_adr_i = '0;
    logic        hold_i = 1'b0;
    logic        halt_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [15:0] instr_o;
    logic [15:0] pc_o;
    logic [2:0]  level_o;
    logic        halted_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    fetch_queue dut (
        .clk_i      (clk_i),
        .rst        (rst),
        .imem_adr_o (imem_adr_o),
        .instr_i    (instr_i),
        .jmp_i      (jmp_i),
        .jmp_adr_i  (jmp_adr_i),
        .hold_i     (hold_i),
        .halt_i     (halt_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .instr_o    (instr_o),
        .pc_o       (pc_o),
        .level_o    (level_o),
        .halted_o   (halted_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return 16'(a * 16'd7) ^ 16'hC3A5;
    endfunction

    assign instr_i = mem_f(imem_adr_o);

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [15:0] pc);
        exp_q.push_back({pc, mem_f(pc)});
    endtask

    // Everything expected from the previous test must have been consumed.
    task automatic do_reset();
        tick();
        chk("drain", 32'(exp_q.size()), 0);
        rst = 1'b1; jmp_i = 1'b0; hold_i = 1'b0; halt_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (!rst && valid_o && ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected actual=%h required=none", {pc_o, instr_o});
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({pc_o, instr_o} !== e) begin
                    errors++;
                    $display("FAIL pop_entry actual=%h required=%h", {pc_o, instr_o}, e);
                end
            end
        end
    end

    initial begin
        tick();
        sample();
        chk("rst_level", 32'(level_o), 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_adr", 32'(imem_adr_o), 0);
        chk("rst_halted", 32'(halted_o), 0);

        // Streaming with ready high.
        do_reset();
        ready_i = 1'b1;
        for (int p = 0; p < 7; p++) exp_push(16'(p));
        sample();
        chk("t1_valid_c0", 32'(valid_o), 0);
        chk("t1_adr_c0", 32'(imem_adr_o), 0);
        for (int c = 1; c < 8; c++) begin
            tick(); sample();
            chk("t1_valid", 32'(valid_o), 1);
            chk("t1_level", 32'(level_o), 1);
            chk("t1_adr", 32'(imem_adr_o), 32'(c));
        end

        // Fill to full, then push+pop at full.
        do_reset();
        ready_i = 1'b0;
        for (int p = 0; p < 4; p++) exp_push(16'(p));
        sample();
        chk("t2_level_c0", 32'(level_o), 0);
        for (int c = 1; c < 6; c++) begin
            tick(); sample();
            chk("t2_fill_level", 32'(level_o), (c > 4) ? 4 : c);
        end
        chk("t2_adr_full", 32'(imem_adr_o), 4);
        for (int c = 6; c < 10; c++) begin
            tick(); ready_i = 1'b1; sample();
            chk("t2_full_level", 32'(level_o), 4);
            chk("t2_full_adr", 32'(imem_adr_o), 32'(c - 2));
        end

        // Redirect with three entries queued.
        do_reset();
        ready_i = 1'b0;
        exp_push(16'h0040); exp_push(16'h0041); exp_push(16'h0042);
        sample();
        tick(); sample();
        tick(); sample();
        tick(); jmp_i = 1'b1; jmp_adr_i = 16'h0040; ready_i = 1'b1; sample();
        chk("t3_valid_jmp", 32'(valid_o), 0);
        chk("t3_level_jmp", 32'(level_o), 3);
        tick(); jmp_i = 1'b0; sample();
        chk("t3_level_flush", 32'(level_o), 0);
        chk("t3_valid_flush", 32'(valid_o), 0);
        chk("t3_adr_target", 32'(imem_adr_o), 32'h0040);
        tick(); sample();
        chk("t3_valid_target", 32'(valid_o), 1);
        chk("t3_pc_target", 32'(pc_o), 32'h0040);
        tick(); sample();
        tick(); sample();

        // Hazard hold for three cycles.
        do_reset();
        ready_i = 1'b1;
        for (int p = 0; p < 5; p++) exp_push(16'(p));
        sample();
        tick(); sample();
        tick(); hold_i = 1'b1; sample();
        chk("t4_level_c2", 32'(level_o), 1);
        chk("t4_adr_c2", 32'(imem_adr_o), 2);
        tick(); sample();
        chk("t4_level_c3", 32'(level_o), 0);
        chk("t4_valid_c3", 32'(valid_o), 0);
        tick(); sample();
        chk("t4_adr_c4", 32'(imem_adr_o), 2);
        tick(); hold_i = 1'b0; sample();
        chk("t4_adr_c5", 32'(imem_adr_o), 2);
        tick(); sample();
        chk("t4_valid_c6", 32'(valid_o), 0);
        chk("t4_adr_c6", 32'(imem_adr_o), 2);
        tick(); sample();
        chk("t4_pc_c7", 32'(pc_o), 2);
        tick(); sample();
        tick(); sample();

        // Halt pulse, drain, then redirect out of HALT.
        do_reset();
        ready_i = 1'b0;
        exp_push(16'h0000); exp_push(16'h0001); exp_push(16'h0100); exp_push(16'h0101);
        sample();
        tick(); sample();
        tick(); halt_i = 1'b1; sample();
        chk("t5_halted_c2", 32'(halted_o), 0);
        tick(); halt_i = 1'b0; ready_i = 1'b1; sample();
        chk("t5_halted_c3", 32'(halted_o), 1);
        chk("t5_level_c3", 32'(level_o), 2);
        chk("t5_adr_c3", 32'(imem_adr_o), 2);
        tick(); sample();
        tick(); sample();
        chk("t5_valid_c5", 32'(valid_o), 0);
        chk("t5_level_c5", 32'(level_o), 0);
        chk("t5_halted_c5", 32'(halted_o), 1);
        chk("t5_adr_c5", 32'(imem_adr_o), 2);
        tick(); jmp_i = 1'b1; jmp_adr_i = 16'h0100; sample();
        chk("t5_halted_c6", 32'(halted_o), 1);
        tick(); jmp_i = 1'b0; sample();
        chk("t5_halted_c7", 32'(halted_o), 0);
        chk("t5_adr_c7", 32'(imem_adr_o), 32'h0100);
        tick(); sample();
        chk("t5_pc_c8", 32'(pc_o), 32'h0100);
        tick(); sample();

        // PC wrap, then reset with a full queue.
        do_reset();
        ready_i = 1'b0; jmp_i = 1'b1; jmp_adr_i = 16'hFFFE;
        exp_push(16'hFFFE);
        sample();
        tick(); jmp_i = 1'b0; sample();
        chk("t6_adr_c1", 32'(imem_adr_o), 32'hFFFE);
        tick(); sample();
        chk("t6_adr_c2", 32'(imem_adr_o), 32'hFFFF);
        tick(); sample();
        chk("t6_adr_wrap", 32'(imem_adr_o), 32'h0000);
        tick(); sample();
        tick(); ready_i = 1'b1; sample();
        chk("t6_level_full", 32'(level_o), 4);
        chk("t6_adr_c5", 32'(imem_adr_o), 2);
        tick(); rst = 1'b1; sample();
        tick(); rst = 1'b0; ready_i = 1'b0; sample();
        chk("t6_level_rst", 32'(level_o), 0);
        chk("t6_valid_rst", 32'(valid_o), 0);
        chk("t6_adr_rst", 32'(imem_adr_o), 0);
        chk("t6_halted_rst", 32'(halted_o), 0);
        tick();
        chk("drain_final", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
